// File: rtl/track_playback_sequencer_pkg.sv
// Shared types and constants for the track playback sequencer.
// Default widths, FSM state encoding and track_sel codes.
package track_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_T1   = 2'b01;
  localparam logic [1:0] SEL_T2   = 2'b10;
  localparam logic [1:0] SEL_MIX  = 2'b11;

endpackage

// File: rtl/playback_addr_counter.sv
// Shared read address register: clear, tick step, terminal flag.
// Ports: clock, reset, clear, step, limit in; addr, last out.
// LOOP_PLAYBACK_EN: address wraps to 0 on the terminal step.
module playback_addr_counter #(
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              step,
  input  logic [ADDR_W-1:0] limit,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  assign last = (addr == limit - ADDR_W'(1));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      addr <= '0;
    end else if (step) begin
`ifdef LOOP_PLAYBACK_EN
      addr <= last ? '0 : addr + ADDR_W'(1);
`else
      addr <= addr + ADDR_W'(1);
`endif
    end
  end

endmodule

// File: rtl/track_playback_sequencer.sv
// Playback sequencer for two note-track memories (track1/track2/mix).
// Ports: clock, reset, tick, play_req, stop_req, track_sel, limit1/2,
//   rdata1/2 in; raddr, cs1, cs2, note_out, note_valid, busy, done out.
// LOOP_PLAYBACK_EN: playback loops at track end instead of finishing.
module track_playback_sequencer
  import track_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick,
  input  logic              play_req,
  input  logic              stop_req,
  input  logic [1:0]        track_sel,
  input  logic [ADDR_W-1:0] limit1,
  input  logic [ADDR_W-1:0] limit2,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  output logic [ADDR_W-1:0] raddr,
  output logic              cs1,
  output logic              cs2,
  output logic [DATA_W-1:0] note_out,
  output logic              note_valid,
  output logic              busy,
  output logic              done
);

  state_t state, state_n;

  logic [1:0]        sel;
  logic [ADDR_W-1:0] lim1, lim2, eff_lim;
  logic [ADDR_W-1:0] eff_in;
  logic [DATA_W-1:0] merged;
  logic              last;
  logic              start;
  logic              emit;

  always_comb begin
    eff_in = '0;
    unique case (track_sel)
      SEL_T1:  eff_in = limit1;
      SEL_T2:  eff_in = limit2;
      SEL_MIX: eff_in = (limit1 > limit2) ? limit1 : limit2;
      default: eff_in = '0;
    endcase
  end

  assign start = (state == IDLE) && play_req && (track_sel != SEL_NONE);
  assign emit  = (state == PLAY) && tick && !stop_req;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = (eff_in == '0) ? DONE : LOAD;
      LOAD: state_n = stop_req ? IDLE : PLAY;
      PLAY: begin
        if (stop_req) state_n = IDLE;
`ifndef LOOP_PLAYBACK_EN
        else if (tick && last) state_n = DONE;
`endif
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sel     <= SEL_NONE;
      lim1    <= '0;
      lim2    <= '0;
      eff_lim <= '0;
    end else if (start) begin
      sel     <= track_sel;
      lim1    <= limit1;
      lim2    <= limit2;
      eff_lim <= eff_in;
    end
  end

  // Address resets whenever playback is not continuing in PLAY,
  // so DONE and IDLE always present address 0.
  playback_addr_counter #(.ADDR_W(ADDR_W)) u_cnt (
    .clock (clock),
    .reset (reset),
    .clear (state_n != PLAY),
    .step  ((state == PLAY) && tick),
    .limit (eff_lim),
    .addr  (raddr),
    .last  (last)
  );

  always_comb begin
    merged = '0;
    unique case (sel)
      SEL_T1:  merged = rdata1;
      SEL_T2:  merged = rdata2;
      SEL_MIX: merged = ((raddr < lim1) ? rdata1 : '0)
                      | ((raddr < lim2) ? rdata2 : '0);
      default: merged = '0;
    endcase
  end

  assign busy = (state == LOAD) || (state == PLAY);
  assign cs1  = busy && sel[0];
  assign cs2  = busy && sel[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      note_out   <= '0;
      note_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      note_valid <= emit;
      done       <= (state == DONE) && !stop_req;
      if (stop_req && state != IDLE) note_out <= '0;
      else if (emit)                 note_out <= merged;
    end
  end

endmodule

// File: tb/tb_track_playback_sequencer.sv
// Directed bench for track_playback_sequencer with model memories.
// Ports of the DUT all driven/observed; summary line at the end.
module tb_track_playback_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       play_req = 1'b0;
  logic       stop_req = 1'b0;
  logic [1:0] track_sel = 2'b00;
  logic [5:0] limit1 = '0;
  logic [5:0] limit2 = '0;
  logic [7:0] rdata1 = '0;
  logic [7:0] rdata2 = '0;
  logic [5:0] raddr;
  logic       cs1, cs2;
  logic [7:0] note_out;
  logic       note_valid, busy, done;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem1 [0:63];
  logic [7:0] mem2 [0:63];

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (cs1) rdata1 <= mem1[raddr];
    if (cs2) rdata2 <= mem2[raddr];
  end

  track_playback_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .play_req   (play_req),
    .stop_req   (stop_req),
    .track_sel  (track_sel),
    .limit1     (limit1),
    .limit2     (limit2),
    .rdata1     (rdata1),
    .rdata2     (rdata2),
    .raddr      (raddr),
    .cs1        (cs1),
    .cs2        (cs2),
    .note_out   (note_out),
    .note_valid (note_valid),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic start_play(input logic [1:0] s);
    track_sel = s;
    play_req  = 1'b1;
    cyc();
    play_req  = 1'b0;
  endtask

  task automatic tick_note(input string tag, input int exp);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk({tag, "_nv"}, note_valid, 1);
    chk({tag, "_note"}, note_out, exp);
    cyc();
    chk({tag, "_nv_low"}, note_valid, 0);
    chk({tag, "_hold"}, note_out, exp);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem1[i] = '0;
      mem2[i] = '0;
    end
    cyc();
    cyc();
    reset = 1'b0;
    chk("rst_raddr", raddr, 0);
    chk("rst_cs", {cs1, cs2}, 0);
    chk("rst_note", note_out, 0);
    chk("rst_flags", {note_valid, busy, done}, 0);

    // track_sel 00 ignored, tick in IDLE ignored
    limit1 = 6'd3;
    start_play(2'b00);
    chk("sel_none_busy", busy, 0);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("idle_tick_nv", note_valid, 0);

`ifndef LOOP_PLAYBACK_EN
    // Test 1: track1 {1,2,4}
    mem1[0] = 8'd1; mem1[1] = 8'd2; mem1[2] = 8'd4;
    start_play(2'b01);
    chk("t1_load_busy", busy, 1);
    chk("t1_load_cs", {cs1, cs2}, 2'b10);
    cyc();
    chk("t1_play_cs", {cs1, cs2}, 2'b10);
    tick_note("t1_n0", 1);
    tick_note("t1_n1", 2);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("t1_n2_nv", note_valid, 1);
    chk("t1_n2_note", note_out, 4);
    chk("t1_n2_done_early", done, 0);
    chk("t1_done_state_cs", {cs1, cs2, busy}, 0);
    cyc();
    chk("t1_done", done, 1);
    chk("t1_done_hold", note_out, 4);
    chk("t1_done_raddr", raddr, 0);
    cyc();
    chk("t1_done_pulse", done, 0);

    // Test 2: mix, limit1=2 {8,8}, limit2=4 {1,2,4,16}
    mem1[0] = 8'd8; mem1[1] = 8'd8; mem1[2] = 8'd64;
    mem2[0] = 8'd1; mem2[1] = 8'd2; mem2[2] = 8'd4; mem2[3] = 8'd16;
    limit1 = 6'd2;
    limit2 = 6'd4;
    start_play(2'b11);
    chk("t2_load_cs", {cs1, cs2}, 2'b11);
    cyc();
    tick_note("t2_n0", 9);
    chk("t2_play_cs", {cs1, cs2}, 2'b11);
    tick_note("t2_n1", 10);
    tick_note("t2_n2", 4);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("t2_n3_note", note_out, 16);
    cyc();
    chk("t2_done", done, 1);

    // Test 3: empty track2
    limit2 = 6'd0;
    start_play(2'b10);
    chk("t3_busy", busy, 0);
    chk("t3_cs2", cs2, 0);
    cyc();
    chk("t3_done", done, 1);
    chk("t3_nv", note_valid, 0);
    chk("t3_cs2_b", cs2, 0);
    cyc();
    chk("t3_done_pulse", done, 0);

    // Test 4: stop with 2nd tick
    mem1[0] = 8'd1; mem1[1] = 8'd2; mem1[2] = 8'd4;
    limit1 = 6'd3;
    start_play(2'b01);
    cyc();
    tick_note("t4_n0", 1);
    tick = 1'b1;
    stop_req = 1'b1;
    cyc();
    tick = 1'b0;
    stop_req = 1'b0;
    chk("t4_nv", note_valid, 0);
    chk("t4_busy", busy, 0);
    chk("t4_note", note_out, 0);
    chk("t4_raddr", raddr, 0);
    cyc();
    chk("t4_done", done, 0);

    // stop together with play in IDLE: play wins
    stop_req = 1'b1;
    start_play(2'b01);
    stop_req = 1'b0;
    chk("idle_play_wins", busy, 1);

    // Test 5: tick in LOAD ignored, play in PLAY ignored, reset mid-PLAY
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("t5_load_tick_nv", note_valid, 0);
    chk("t5_load_tick_raddr", raddr, 0);
    tick_note("t5_n0", 1);
    play_req = 1'b1;
    cyc();
    play_req = 1'b0;
    chk("t5_play_ignored", raddr, 1);
    chk("t5_play_busy", busy, 1);
    tick_note("t5_n1", 2);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t5_rst_raddr", raddr, 0);
    chk("t5_rst_note", note_out, 0);
    chk("t5_rst_flags", {cs1, cs2, note_valid, busy, done}, 0);
`else
    // Test 6: loop playback, limit1=2 {1,2}
    mem1[0] = 8'd1; mem1[1] = 8'd2;
    limit1 = 6'd2;
    start_play(2'b01);
    cyc();
    tick_note("t6_n0", 1);
    tick_note("t6_n1", 2);
    chk("t6_no_done_a", done, 0);
    tick_note("t6_n2", 1);
    tick_note("t6_n3", 2);
    tick_note("t6_n4", 1);
    chk("t6_busy", busy, 1);
    chk("t6_no_done_b", done, 0);
    stop_req = 1'b1;
    cyc();
    stop_req = 1'b0;
    chk("t6_stop_busy", busy, 0);
    chk("t6_stop_note", note_out, 0);
    cyc();
    chk("t6_stop_done", done, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
